// File: rtl/logical_ops_resp_checker_if.sv
// Stimulus and response channels between a driver and the logical-operator
// response checker. The stimulus side carries operand pairs with a
// valid/ready handshake. The response side carries the operator block's
// 1-bit results and has no backpressure.
interface logical_ops_resp_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             res_valid;
  logic             and_op;
  logic             or_op;
  logic             not_op;

  // Driver side: produces operands and the results under test.
  modport master (
    output in_valid, a, b, res_valid, and_op, or_op, not_op,
    input  in_ready
  );

  // Checker side.
  modport slave (
    input  in_valid, a, b, res_valid, and_op, or_op, not_op,
    output in_ready
  );
endinterface

// File: rtl/logical_ops_resp_checker.sv
// Response checker for the 4-bit logical-operator block.
// Accepted operand pairs are turned into expected {and,or,not} results and
// queued. Each response pops the queue head and is compared against it.
// Passes and failures are counted with saturating counters. A response that
// arrives while the queue is empty is an orphan: it is counted as a failure
// and sets a sticky flag.
// Optional feature macro LOGOP_CHK_CAPTURE_EN: when it is defined, the
// operands, the received result and the expected result of the first failure
// are latched. When it is undefined, those outputs are tied to zero.
module logical_ops_resp_checker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  logical_ops_resp_checker_if.slave   bus,
  output logic                        mismatch,
  output logic [CNT_W-1:0]            pass_cnt,
  output logic [CNT_W-1:0]            fail_cnt,
  output logic                        orphan,
  output logic                        busy,
  output logic                        done,
  output logic                        all_pass,
  output logic                        fail_valid,
  output logic [WIDTH-1:0]            fail_a,
  output logic [WIDTH-1:0]            fail_b,
  output logic [2:0]                  fail_got,
  output logic [2:0]                  fail_exp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LOGOP_CHK_CAPTURE_EN
  // Each queue entry holds the operands alongside the expected result so
  // that a failure record can be captured.
  localparam int ENT_W = 2*WIDTH + 3;
`else
  localparam int ENT_W = 3;
`endif

  // Expected {and,or,not}, where each operand is reduced to a truth value.
  function automatic logic [2:0] logop_exp(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic ta, tb;
    ta = |a;
    tb = |b;
    return {ta && tb, ta || tb, !ta};
  endfunction

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q, state_d;
  logic             clear;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mismatch_q, orphan_q, busy_q, done_q;
  logic [CNT_W-1:0] pass_q, fail_q;

  logic             resp_en, in_ready_w, push, pop, orph_ev;
  logic             pass_ev, fail_ev;
  logic [2:0]       got, head_exp;
  logic [ENT_W-1:0] head, ent_push;

  assign resp_en    = (state_q == S_RUN) || (state_q == S_DRAIN);
  // Depends only on the state and the registered occupancy, so a full
  // queue blocks a push even while a pop is happening in the same cycle.
  assign in_ready_w = (state_q == S_RUN) && (cnt_q < DEPTH_C);
  assign bus.in_ready = in_ready_w;

  assign push     = bus.in_valid && in_ready_w;
  assign pop      = resp_en && bus.res_valid && (cnt_q != '0);
  assign orph_ev  = resp_en && bus.res_valid && (cnt_q == '0);
  assign got      = {bus.and_op, bus.or_op, bus.not_op};
  assign head     = mem_q[rd_ptr_q];
  assign head_exp = head[2:0];
  assign pass_ev  = pop && (got == head_exp);
  assign fail_ev  = (pop && (got != head_exp)) || orph_ev;

`ifdef LOGOP_CHK_CAPTURE_EN
  assign ent_push = {bus.a, bus.b, logop_exp(bus.a, bus.b)};
`else
  assign ent_push = logop_exp(bus.a, bus.b);
`endif

  // Next state and start-clear decode. A stop in RUN wins over a start.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE:  if (start) begin state_d = S_RUN; clear = 1'b1; end
      S_RUN:   if (stop) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (start) begin state_d = S_RUN; clear = 1'b1; end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy update. A simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue storage: data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ent_push;
  end

  // Control state, queue pointers, registered compare result and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      orphan_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      if (clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        mismatch_q <= 1'b0;
        orphan_q   <= 1'b0;
        pass_q     <= '0;
        fail_q     <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        cnt_q      <= cnt_d;
        mismatch_q <= fail_ev;
        if (orph_ev) orphan_q <= 1'b1;
        if (pass_ev) pass_q <= sat_inc(pass_q);
        if (fail_ev) fail_q <= sat_inc(fail_q);
      end
    end
  end

`ifdef LOGOP_CHK_CAPTURE_EN
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q;
  logic [2:0]       fail_got_q, fail_exp_q;

  // First-failure record. An orphan has no queue entry, so its operand and
  // expected fields are recorded as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else if (clear) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else if (fail_ev && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_got_q   <= got;
      if (orph_ev) begin
        fail_a_q   <= '0;
        fail_b_q   <= '0;
        fail_exp_q <= '0;
      end else begin
        fail_a_q   <= head[ENT_W-1 -: WIDTH];
        fail_b_q   <= head[ENT_W-WIDTH-1 -: WIDTH];
        fail_exp_q <= head_exp;
      end
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_got   = fail_got_q;
  assign fail_exp   = fail_exp_q;
`else
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
  assign fail_got   = '0;
  assign fail_exp   = '0;
`endif

  assign mismatch = mismatch_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign orphan   = orphan_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign all_pass = done_q && (fail_q == '0) && !orphan_q;

endmodule

// File: tb/tb_logical_ops_resp_checker.sv
// Directed bench for logical_ops_resp_checker. dut uses the default
// parameters. dut2 uses 4-bit counters so that counter saturation is
// reached in a few cycles.
module tb_logical_ops_resp_checker;

  logic clk = 1'b0;
  logic rst, start, stop, start2, stop2;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logical_ops_resp_checker_if #(.WIDTH(4)) bus1 ();
  logical_ops_resp_checker_if #(.WIDTH(4)) bus2 ();

  logic        mismatch, orphan, busy, done, all_pass, fail_valid;
  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0]  fail_a, fail_b;
  logic [2:0]  fail_got, fail_exp;

  logic        mismatch2, orphan2, busy2, done2, all_pass2, fail_valid2;
  logic [3:0]  pass_cnt2, fail_cnt2;
  logic [3:0]  fail_a2, fail_b2;
  logic [2:0]  fail_got2, fail_exp2;

  logical_ops_resp_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus1),
    .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .orphan(orphan), .busy(busy), .done(done), .all_pass(all_pass),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
    .fail_got(fail_got), .fail_exp(fail_exp)
  );

  logical_ops_resp_checker #(.WIDTH(4), .DEPTH(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .bus(bus2),
    .mismatch(mismatch2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
    .orphan(orphan2), .busy(busy2), .done(done2), .all_pass(all_pass2),
    .fail_valid(fail_valid2), .fail_a(fail_a2), .fail_b(fail_b2),
    .fail_got(fail_got2), .fail_exp(fail_exp2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic drive_push(input logic [3:0] a, input logic [3:0] b);
    bus1.in_valid = 1'b1; bus1.a = a; bus1.b = b;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  task automatic drive_resp(input logic [2:0] r);
    bus1.res_valid = 1'b1;
    {bus1.and_op, bus1.or_op, bus1.not_op} = r;
    tick();
    bus1.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({bus1.in_ready, mismatch, orphan, busy, done, all_pass, fail_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000000",
               {bus1.in_ready, mismatch, orphan, busy, done, all_pass, fail_valid});
    end
    total++;
    if ({pass_cnt, fail_cnt, fail_a, fail_b, fail_got, fail_exp} !== 46'b0) begin
      bad++;
      $display("FAIL reset_values got pass=%0d fail=%0d a=%b b=%b got=%b exp=%b want all 0",
               pass_cnt, fail_cnt, fail_a, fail_b, fail_got, fail_exp);
    end
    rst = 1'b0;
    tick();
    // Responses in IDLE are ignored.
    drive_resp(3'b111);
    tick();
    total++;
    if ({orphan, mismatch, fail_cnt, bus1.in_ready} !== 19'b0) begin
      bad++;
      $display("FAIL idle_ignore got orphan=%b mis=%b fail=%0d rdy=%b want 0",
               orphan, mismatch, fail_cnt, bus1.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [2:0] vr [4];
    va = '{4'b0000, 4'b0000, 4'b0010, 4'b1111};
    vb = '{4'b0000, 4'b0001, 4'b0000, 4'b1111};
    vr = '{3'b001, 3'b011, 3'b010, 3'b110};
    pulse_start();
    total++;
    if ({busy, done, bus1.in_ready} !== 3'b101) begin
      bad++;
      $display("FAIL basic_run got busy/done/rdy=%b want 101", {busy, done, bus1.in_ready});
    end
    for (int i = 0; i < 4; i++) drive_push(va[i], vb[i]);
    total++;
    if (bus1.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_full_ready got=%b want=0", bus1.in_ready);
    end
    pulse_stop();
    total++;
    if ({busy, done, bus1.in_ready} !== 3'b100) begin
      bad++;
      $display("FAIL basic_drain got busy/done/rdy=%b want 100", {busy, done, bus1.in_ready});
    end
    for (int i = 0; i < 4; i++) begin
      drive_resp(vr[i]);
      total++;
      if (mismatch !== 1'b0) begin
        bad++;
        $display("FAIL basic_resp%0d mismatch got=%b want=0", i, mismatch);
      end
    end
    total++;
    if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_counts got pass=%0d fail=%0d done=%b want 4 0 0",
               pass_cnt, fail_cnt, done);
    end
    tick();
    total++;
    if ({done, busy, all_pass} !== 3'b101) begin
      bad++;
      $display("FAIL basic_done got done/busy/all_pass=%b want 101", {done, busy, all_pass});
    end
  endtask

  task automatic test_mismatch();
    pulse_start();
    total++;
    if (pass_cnt !== 16'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_clear got pass=%0d done=%b want 0 0", pass_cnt, done);
    end
    drive_push(4'b0001, 4'b0001);
    drive_resp(3'b100);
    total++;
    if (mismatch !== 1'b1 || fail_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mis_pulse got mis=%b fail=%0d pass=%0d want 1 1 0",
               mismatch, fail_cnt, pass_cnt);
    end
    tick();
    total++;
    if (mismatch !== 1'b0) begin
      bad++;
      $display("FAIL mis_one_cycle got=%b want=0", mismatch);
    end
    drive_push(4'b0011, 4'b0000);
    drive_resp(3'b000);
    total++;
    if (fail_cnt !== 16'd2) begin
      bad++;
      $display("FAIL mis_second got fail=%0d want=2", fail_cnt);
    end
`ifdef LOGOP_CHK_CAPTURE_EN
    total++;
    if ({fail_valid, fail_a, fail_b, fail_got, fail_exp} !== {1'b1, 4'b0001, 4'b0001, 3'b100, 3'b110}) begin
      bad++;
      $display("FAIL capture_first got v=%b a=%b b=%b got=%b exp=%b want 1 0001 0001 100 110",
               fail_valid, fail_a, fail_b, fail_got, fail_exp);
    end
`else
    total++;
    if ({fail_valid, fail_a, fail_b, fail_got, fail_exp} !== 15'b0) begin
      bad++;
      $display("FAIL capture_tied got v=%b a=%b b=%b got=%b exp=%b want 0",
               fail_valid, fail_a, fail_b, fail_got, fail_exp);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int accepts;
    accepts = 0;
    bus1.in_valid = 1'b1; bus1.a = 4'b1111; bus1.b = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (bus1.in_ready === 1'b1) accepts++;
      tick();
    end
    total++;
    if (accepts != 4 || bus1.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accepts got=%0d rdy=%b want 4 0", accepts, bus1.in_ready);
    end
    bus1.res_valid = 1'b1;
    {bus1.and_op, bus1.or_op, bus1.not_op} = 3'b110;
    #1;
    total++;
    if (bus1.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_during_pop got=%b want=0", bus1.in_ready);
    end
    tick();
    bus1.res_valid = 1'b0;
    total++;
    if (bus1.in_ready !== 1'b1 || pass_cnt !== 16'd1) begin
      bad++;
      $display("FAIL b2b_ready_after_pop got rdy=%b pass=%0d want 1 1", bus1.in_ready, pass_cnt);
    end
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) drive_resp(3'b110);
    total++;
    if (pass_cnt !== 16'd4 || fail_cnt !== 16'd2 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got pass=%0d fail=%0d mis=%b want 4 2 0",
               pass_cnt, fail_cnt, mismatch);
    end
  endtask

  task automatic test_orphan();
    bus1.in_valid = 1'b1; bus1.a = 4'b0000; bus1.b = 4'b0000;
    drive_resp(3'b001);
    bus1.in_valid = 1'b0;
    total++;
    if ({orphan, mismatch} !== 2'b11 || fail_cnt !== 16'd3 || pass_cnt !== 16'd4) begin
      bad++;
      $display("FAIL orphan_flag got orphan=%b mis=%b fail=%0d pass=%0d want 1 1 3 4",
               orphan, mismatch, fail_cnt, pass_cnt);
    end
    drive_resp(3'b001);
    total++;
    if (pass_cnt !== 16'd5 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL orphan_push_kept got pass=%0d mis=%b want 5 0", pass_cnt, mismatch);
    end
    drive_resp(3'b001);
    total++;
    if (fail_cnt !== 16'd4 || orphan !== 1'b1) begin
      bad++;
      $display("FAIL orphan_one_entry got fail=%0d orphan=%b want 4 1", fail_cnt, orphan);
    end
`ifdef LOGOP_CHK_CAPTURE_EN
    total++;
    if (fail_a !== 4'b0001 || fail_got !== 3'b100) begin
      bad++;
      $display("FAIL capture_kept got a=%b got=%b want 0001 100", fail_a, fail_got);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_push(4'b1111, 4'b1111);
    pulse_stop();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus1.in_ready, mismatch, orphan, busy, done, all_pass, fail_valid} !== 7'b0) begin
      bad++;
      $display("FAIL midrst_flags got=%b want=0000000",
               {bus1.in_ready, mismatch, orphan, busy, done, all_pass, fail_valid});
    end
    total++;
    if ({pass_cnt, fail_cnt, fail_a, fail_b, fail_got, fail_exp} !== 46'b0) begin
      bad++;
      $display("FAIL midrst_values got pass=%0d fail=%0d a=%b b=%b got=%b exp=%b want all 0",
               pass_cnt, fail_cnt, fail_a, fail_b, fail_got, fail_exp);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || bus1.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle got busy=%b rdy=%b want 0 0", busy, bus1.in_ready);
    end
    pulse_start();
    drive_push(4'b0000, 4'b0001);
    drive_resp(3'b011);
    total++;
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || mismatch !== 1'b0) begin
      bad++;
      $display("FAIL midrst_restart got pass=%0d fail=%0d mis=%b want 1 0 0",
               pass_cnt, fail_cnt, mismatch);
    end
  endtask

  task automatic test_capture_orphan();
    drive_resp(3'b101);
    total++;
    if (orphan !== 1'b1 || fail_cnt !== 16'd1) begin
      bad++;
      $display("FAIL corph_count got orphan=%b fail=%0d want 1 1", orphan, fail_cnt);
    end
`ifdef LOGOP_CHK_CAPTURE_EN
    total++;
    if ({fail_valid, fail_a, fail_b, fail_got, fail_exp} !== {1'b1, 4'b0000, 4'b0000, 3'b101, 3'b000}) begin
      bad++;
      $display("FAIL corph_record got v=%b a=%b b=%b got=%b exp=%b want 1 0000 0000 101 000",
               fail_valid, fail_a, fail_b, fail_got, fail_exp);
    end
`endif
    pulse_stop();
    tick();
    total++;
    if ({done, busy, all_pass} !== 3'b100) begin
      bad++;
      $display("FAIL corph_done got done/busy/all_pass=%b want 100", {done, busy, all_pass});
    end
  endtask

  task automatic test_saturate();
    start2 = 1'b1; tick(); start2 = 1'b0;
    bus2.res_valid = 1'b1;
    {bus2.and_op, bus2.or_op, bus2.not_op} = 3'b000;
    repeat (14) tick();
    total++;
    if (fail_cnt2 !== 4'hE || mismatch2 !== 1'b1) begin
      bad++;
      $display("FAIL sat_preload got fail=%0h mis=%b want e 1", fail_cnt2, mismatch2);
    end
    repeat (3) tick();
    bus2.res_valid = 1'b0;
    total++;
    if (fail_cnt2 !== 4'hF || mismatch2 !== 1'b1 || orphan2 !== 1'b1 || pass_cnt2 !== 4'h0) begin
      bad++;
      $display("FAIL sat_hold got fail=%0h mis=%b orphan=%b pass=%0h want f 1 1 0",
               fail_cnt2, mismatch2, orphan2, pass_cnt2);
    end
    total++;
    if ({busy2, done2, all_pass2, bus2.in_ready} !== 4'b1001 ||
        {fail_valid2 & 1'b0, fail_a2, fail_b2, fail_got2, fail_exp2} !== 15'b0) begin
      bad++;
      $display("FAIL sat_misc got busy/done/ap/rdy=%b a=%b b=%b got=%b exp=%b",
               {busy2, done2, all_pass2, bus2.in_ready}, fail_a2, fail_b2, fail_got2, fail_exp2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.res_valid = 1'b0;
    bus1.and_op = 1'b0; bus1.or_op = 1'b0; bus1.not_op = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.res_valid = 1'b0;
    bus2.and_op = 1'b0; bus2.or_op = 1'b0; bus2.not_op = 1'b0;
    test_reset();
    test_basic();
    test_mismatch();
    test_back_to_back();
    test_orphan();
    test_reset_mid();
    test_capture_orphan();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/logical_ops_resp_checker.md
# logical_ops_resp_checker

Synthesizable response checker for the 4-bit logical-operator block (`&&`, `||`, `!` reduced to 1-bit results). It accepts operand pairs on a stimulus channel and queues the expected results. It then compares them, in order, against the results on a response channel, and counts passes and failures. It sits beside the operator block in on-chip self-test and FPGA bring-up, where the simulation-only monitor is unavailable.

## Interface
Parameters:
- `WIDTH`, 4: operand width.
- `DEPTH`, 4: expected-result queue entries (power of two, ≥2).
- `CNT_W`, 16: width of the pass and fail counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; IDLE→RUN, clears counters and queue.
- `stop` in 1: pulse; RUN→DRAIN.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: checker accepts the pair.
- `a`, `b` in WIDTH: operands.
- `res_valid` in 1: DUT result present (no backpressure).
- `and_op`, `or_op`, `not_op` in 1: DUT results.
- `mismatch` out 1: one-cycle pulse on a failed compare or an orphan response.
- `pass_cnt`, `fail_cnt` out CNT_W: saturating counters.
- `orphan` out 1: sticky; a response arrived while the queue was empty.
- `busy` out 1: state is RUN or DRAIN.
- `done` out 1: state is DONE.
- `all_pass` out 1: `done && fail_cnt==0 && !orphan`.
- `fail_valid` out 1: first-failure record is valid.
- `fail_a`, `fail_b` out WIDTH: operands of the first failure.
- `fail_got`, `fail_exp` out 3: `{and,or,not}` received and expected for the first failure.

## Operation
- Expected values per accepted pair: and = `(|a)&&(|b)`; or = `(|a)||(|b)`; not = `~|a`. Each is stored with `a` and `b` as one queue entry.
- Push on `in_valid && in_ready`. Pop on `res_valid` when the queue is non-empty. The popped entry is compared against `{and_op,or_op,not_op}`.
- Counters: equal increments `pass_cnt`, unequal increments `fail_cnt`. Both hold at all-ones; they do not wrap.
- `res_valid` with an empty queue sets `orphan`, pulses `mismatch`, and increments `fail_cnt`. There is no pop and no same-cycle bypass from a simultaneous push.
- Simultaneous push and pop: occupancy is unchanged, and both take effect.
- FSM:
  - IDLE: `in_ready`=0 and responses are ignored. `start` → RUN, clearing counters, queue, `orphan`, and the failure record.
  - RUN: `in_ready = (count<DEPTH)`. `stop` → DRAIN. If `start` and `stop` arrive together, `stop` wins.
  - DRAIN: `in_ready`=0 and pops continue. When the queue is empty → DONE.
  - DONE: outputs hold. `start` → RUN, with the same clears.
- `rst` mid-operation discards all queue contents and returns to IDLE immediately.

## Timing
- Reset values: state IDLE; `in_ready`, `mismatch`, `orphan`, `busy`, `done`, `all_pass`, `fail_valid` = 0; `pass_cnt`, `fail_cnt`, `fail_a`, `fail_b`, `fail_got`, `fail_exp` = 0.
- `in_ready` is combinational from the state and the registered count. It does not depend on a same-cycle pop, so it is low when the queue is full, even during a pop.
- The compare result is registered. `mismatch` and the counter updates are visible one cycle after the `res_valid` edge.
- `busy` and `done` are registered and change on the edge after the transition condition.
- DRAIN→DONE occurs on the edge after the last pop. `all_pass` is valid in the same cycle as `done`.
- Throughput: one push and one pop per cycle.

## Configuration
- `LOGOP_CHK_CAPTURE_EN` defined: the first failure (compare mismatch or orphan) latches `fail_a`, `fail_b`, `fail_got`, and `fail_exp`, and sets `fail_valid`. For an orphan, the operand and expected fields are 0. Later failures do not overwrite the record. It is cleared by `start` and `rst`.
- Not defined: the capture registers are not built. `fail_valid`, `fail_a`, `fail_b`, `fail_got`, and `fail_exp` are tied to 0. All other behaviour is identical.

## Test plan
- Reset, `start`, then push a=0000,b=0000 / a=0000,b=0001 / a=0010,b=0000 / a=1111,b=1111. Return responses 001 / 011 / 010 / 110, then `stop` → `pass_cnt`=4, `fail_cnt`=0, `done`=1 one cycle after the last pop, `all_pass`=1.
- Push a=0001,b=0001 and return 100 (expected 110) → `mismatch` pulse one cycle later, `fail_cnt`=1. With `LOGOP_CHK_CAPTURE_EN`: `fail_a`=0001, `fail_b`=0001, `fail_got`=100, `fail_exp`=110.
- Hold `in_valid`=1 with no responses → `in_ready` falls after 4 accepts. A `res_valid` while full keeps `in_ready`=0 that cycle and raises it the next cycle.
- `res_valid` in RUN with an empty queue and a simultaneous push → `orphan`=1, `fail_cnt`=1, and the queue holds one entry.
- Preload `fail_cnt`=all-ones−1 via failures and apply 3 more mismatches → `fail_cnt` saturates at 0xFFFF.
- Assert `rst` with 3 entries queued in DRAIN → state IDLE, `busy`=0, and all outputs at their reset values. After a new `start` and one push plus a correct response, `pass_cnt`=1.
